// File: rtl/dm_pkg.sv
// Shared types for the data-memory responder: FSM encoding, MMIO offsets and
// the address-decode result.
package dm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } dm_state_t;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_LED,
        REG_SW,
        REG_MMIO_NULL,
        REG_ERR
    } dm_region_t;

    localparam logic [9:0] LED_OFS = 10'h000;
    localparam logic [9:0] SW_OFS  = 10'h004;

endpackage

// File: rtl/dm_ram.sv
// Word-wide synchronous RAM with byte-lane write enables and a registered
// read port. Contents are deliberately left unreset.
module dm_ram #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory bus target: fixed-latency load/store responder backing a RAM and
// an MMIO window (LED data register, synchronized switches).
module dm_responder
    import dm_pkg::*;
#(
    parameter int          DEPTH_LOG2  = 6,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_be,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_err,
    input  logic [2:0]  sw,
    output logic [31:0] led_data
);

    localparam logic [32:0] RAM_BYTES = 33'd4 << DEPTH_LOG2;
    localparam logic [3:0]  LAST_WAIT = 4'(WAIT_CYCLES - 1);

    dm_state_t  state, state_nxt;
    dm_region_t region;
    logic [3:0] cnt;
    logic       commit;

    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q, wdata_q;

    logic        acc_we;
    logic [3:0]  acc_be;
    logic [31:0] acc_addr, acc_wdata;

    logic [2:0]  sw_meta, sw_sync;
    logic        rd_from_ram;
    logic [31:0] rdata_q, ram_rdata;
    logic        ram_we, ram_re;

    // With zero wait states the access commits on the accept edge, so the
    // live request fields are used while still in IDLE.
    always_comb begin
        if (state == ST_IDLE) begin
            acc_we    = mem_we;
            acc_be    = mem_be;
            acc_addr  = mem_addr;
            acc_wdata = mem_wdata;
        end else begin
            acc_we    = we_q;
            acc_be    = be_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = ST_RESP;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == LAST_WAIT) begin
                    state_nxt = ST_RESP;
                    commit    = 1'b1;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // RAM takes priority if the MMIO window were ever placed inside it.
    always_comb begin
        region = REG_ERR;
        if (acc_addr[1:0] != 2'b00) begin
            region = REG_ERR;
        end else if ({1'b0, acc_addr} < RAM_BYTES) begin
            region = REG_RAM;
        end else if (acc_addr[31:10] == MMIO_BASE[31:10]) begin
            if (acc_addr[9:0] == LED_OFS) begin
                region = REG_LED;
            end else if (acc_addr[9:0] == SW_OFS) begin
                region = REG_SW;
            end else begin
                region = REG_MMIO_NULL;
            end
        end
    end

    assign ram_we = commit && acc_we && (region == REG_RAM);
    assign ram_re = commit && !acc_we && (region == REG_RAM);

    dm_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (acc_be),
        .re    (ram_re),
        .addr  (acc_addr[DEPTH_LOG2+1:2]),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && mem_req) begin
                cnt     <= '0;
                we_q    <= mem_we;
                be_q    <= mem_be;
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end else if (state == ST_WAIT) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_data <= '0;
        end else if (commit && acc_we && region == REG_LED) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    led_data[8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    // RAM load data arrives from the RAM's own read register; everything else
    // is captured in rdata_q on the commit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_err     <= 1'b0;
            rd_from_ram <= 1'b0;
            rdata_q     <= '0;
        end else if (commit) begin
            mem_err     <= (region == REG_ERR);
            rd_from_ram <= !acc_we && (region == REG_RAM);
            if (!acc_we && region == REG_LED) begin
                rdata_q <= led_data;
            end else if (!acc_we && region == REG_SW) begin
                rdata_q <= {29'b0, sw_sync};
            end else begin
                rdata_q <= '0;
            end
        end else if (state == ST_RESP) begin
            mem_err     <= 1'b0;
            rd_from_ram <= 1'b0;
            rdata_q     <= '0;
        end
    end

    assign mem_ready = (state == ST_RESP);
    assign mem_rdata = rd_from_ram ? ram_rdata : rdata_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: one instance with zero wait states and one with one
// wait state, each checked against a spec-level model through a response queue.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [2:0]  sw = 3'b000;

    logic        ready0, ready1, err0, err1;
    logic [31:0] rdata0, rdata1, led0, led1;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    logic [32:0] mon_e0, mon_e1;

    logic [31:0] ram_m[2][64];
    logic [31:0] led_m[2];

    always #5 clk = ~clk;

    dm_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0), .MMIO_BASE(32'h400)) dut_w0 (
        .clk(clk), .rst_n(rst_n), .mem_req(req0), .mem_we(we), .mem_be(be),
        .mem_addr(addr), .mem_wdata(wdata), .mem_ready(ready0), .mem_rdata(rdata0),
        .mem_err(err0), .sw(sw), .led_data(led0)
    );

    dm_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(1), .MMIO_BASE(32'h400)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .mem_req(req1), .mem_we(we), .mem_be(be),
        .mem_addr(addr), .mem_wdata(wdata), .mem_ready(ready1), .mem_rdata(rdata1),
        .mem_err(err1), .sw(sw), .led_data(led1)
    );

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level model: returns {err, rdata} and updates the modelled state.
    task automatic model(input int d, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [32:0] e);
        logic [31:0] rd;
        logic        er;
        logic [31:0] word;
        rd = 32'h0;
        er = 1'b0;
        if (a % 4 != 0) begin
            er = 1'b1;
        end else if (a < 256) begin
            word = ram_m[d][a / 4];
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) word[8*i +: 8] = wd[8*i +: 8];
                ram_m[d][a / 4] = word;
            end else begin
                rd = word;
            end
        end else if (a >= 32'h400 && a < 32'h800) begin
            if (a == 32'h400) begin
                word = led_m[d];
                if (w) begin
                    for (int i = 0; i < 4; i++)
                        if (b[i]) word[8*i +: 8] = wd[8*i +: 8];
                    led_m[d] = word;
                end else begin
                    rd = word;
                end
            end else if (a == 32'h404 && !w) begin
                rd = {29'b0, sw};
            end
        end else begin
            er = 1'b1;
        end
        e = {er, rd};
    endtask

    // Issue one request on instance d and hold it until mem_ready.
    task automatic access(input int d, input logic w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] wd);
        logic [32:0] e;
        int          cyc;
        logic        got;
        model(d, w, b, a, wd, e);
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        @(posedge clk);
        #1;
        we = w; be = b; addr = a; wdata = wd;
        if (d == 0) req0 = 1'b1;
        else        req1 = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            got = (d == 0) ? ready0 : ready1;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        // One negedge precedes the accept edge; ready follows WAIT_CYCLES+1 edges later.
        chk($sformatf("latency_w%0d", d), 33'(cyc), 33'(d + 2));
        chk($sformatf("led_w%0d", d), {1'b0, (d == 0) ? led0 : led1}, {1'b0, led_m[d]});
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ready0 === 1'b1) begin
            if (exp_q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready_w0: got ready=1 required no response");
            end else begin
                mon_e0 = exp_q0.pop_front();
                chk("resp_w0 {err,rdata}", {err0, rdata0}, mon_e0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ready1 === 1'b1) begin
            if (exp_q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready_w1: got ready=1 required no response");
            end else begin
                mon_e1 = exp_q1.pop_front();
                chk("resp_w1 {err,rdata}", {err1, rdata1}, mon_e1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        led_m[0] = 32'h0;
        led_m[1] = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset_ready_w0", {32'h0, ready0}, 33'h0);
        chk("reset_ready_w1", {32'h0, ready1}, 33'h0);
        chk("reset_rdata_w0", {err0, rdata0}, 33'h0);
        chk("reset_rdata_w1", {err1, rdata1}, 33'h0);
        chk("reset_led_w0", {1'b0, led0}, 33'h0);
        chk("reset_led_w1", {1'b0, led1}, 33'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 64; i++)
                access(d, 1'b1, 4'hF, 32'(i * 4), $urandom);

        for (int d = 0; d < 2; d++) begin
            access(d, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
            access(d, 1'b0, 4'hF, 32'h10, 32'h0);
            access(d, 1'b1, 4'b0001, 32'h10, 32'h0000_00AA);
            access(d, 1'b0, 4'hF, 32'h10, 32'h0);
            access(d, 1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF);
            access(d, 1'b0, 4'hF, 32'h10, 32'h0);
            access(d, 1'b1, 4'hF, 32'h400, 32'h1234_5678);
            access(d, 1'b0, 4'hF, 32'h400, 32'h0);
            access(d, 1'b1, 4'hF, 32'h404, 32'hFFFF_FFFF);
            access(d, 1'b0, 4'hF, 32'h404, 32'h0);
            sw = 3'b101;
            repeat (3) @(posedge clk);
            access(d, 1'b0, 4'hF, 32'h404, 32'h0);
            access(d, 1'b0, 4'hF, 32'h11, 32'h0);
            access(d, 1'b1, 4'hF, 32'h200, 32'h5555_5555);
            access(d, 1'b1, 4'hF, 32'h402, 32'h6666_6666);
            access(d, 1'b0, 4'hF, 32'h10, 32'h0);
            access(d, 1'b0, 4'hF, 32'h400, 32'h0);
            access(d, 1'b0, 4'hF, 32'h408, 32'h0);
            access(d, 1'b0, 4'hF, 32'hFC, 32'h0);
        end

        // Reset in the middle of a store's wait state must abort it silently.
        @(posedge clk);
        #1;
        we = 1'b1; be = 4'hF; addr = 32'h400; wdata = 32'hCAFE_F00D; req1 = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req1 = 1'b0;
        led_m[0] = 32'h0;
        led_m[1] = 32'h0;
        repeat (2) @(negedge clk);
        chk("abort_led_in_reset", {1'b0, led1}, 33'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_ready", {32'h0, ready1}, 33'h0);
        end
        chk("abort_led_after", {1'b0, led1}, 33'h0);
        access(1, 1'b0, 4'hF, 32'h10, 32'h0);
        access(0, 1'b0, 4'hF, 32'h10, 32'h0);
        access(1, 1'b0, 4'hF, 32'h400, 32'h0);

        for (int n = 0; n < 160; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                sw = 3'($urandom_range(0, 7));
                repeat (3) @(posedge clk);
            end
            case ($urandom_range(0, 7))
                0, 1, 2: a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                3:       a = 32'h400;
                4:       a = 32'h404;
                5:       a = 32'h400 + 32'($urandom_range(2, 255) * 4);
                6:       a = 32'($urandom_range(1, 32'h7FF));
                default: a = $urandom;
            endcase
            access(n % 2, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom);
        end

        repeat (4) @(negedge clk);
        chk("queue_empty_w0", 33'(exp_q0.size()), 33'h0);
        chk("queue_empty_w1", 33'(exp_q1.size()), 33'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
